// File: rtl/fft_ctrl_pkg.sv
// Shared types and helpers for the MDC FFT pipeline control blocks.
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam int unsigned DEF_MAX_LOG2N = 10;
  localparam int unsigned DEF_MIN_LOG2N = 3;

  // A_s = 2^(L-1) - 2^(L-1-s); stages s >= L-1 are unused and report 0.
  function automatic int unsigned arm_offset(input int unsigned l, input int unsigned s);
    if (s + 32'd1 >= l) return 32'd0;
    return (32'd1 << (l - 32'd1)) - (32'd1 << (l - 32'd1 - s));
  endfunction

  function automatic int unsigned drain_len(input int unsigned l);
    return (32'd1 << (l - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/mdc_stage_sel.sv
// One commutator stage: sticky arming and the registered switch select bit.
import fft_ctrl_pkg::*;

module mdc_stage_sel #(
  parameter int unsigned MAX_LOG2N = DEF_MAX_LOG2N,
  parameter int unsigned STAGE     = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_fire,
  input  logic                 i_pre_clr,
  input  logic                 i_post_clr,
  input  logic [MAX_LOG2N-1:0] i_idx,
  input  logic [3:0]           i_log2n,
  output logic                 o_sel
);

  localparam int unsigned W = MAX_LOG2N;

  logic         r_armed;
  logic         r_sel;
  logic [W-1:0] w_off;
  logic [W-1:0] w_mask;
  logic [W-1:0] w_diff;
  logic [3:0]   w_sh;
  logic         w_active;
  logic         w_hit;
  logic         w_arm_eff;
  logic         w_bit;

  assign w_active  = (32'(i_log2n) >= STAGE + 32'd2);
  assign w_off     = W'(arm_offset(32'(i_log2n), STAGE));
  assign w_mask    = W'((32'd1 << i_log2n) - 32'd1);
  assign w_hit     = w_active && (i_idx >= w_off);
  // Arming applies to the current sample itself, so a clear and a re-arm can coincide.
  assign w_arm_eff = w_active && ((r_armed && !i_pre_clr) || w_hit);
  assign w_diff    = (i_idx - w_off) & w_mask;
  assign w_sh      = w_active ? (i_log2n - 4'(STAGE) - 4'd2) : 4'd0;
  assign w_bit     = |(w_diff & (W'(1) << w_sh));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_armed <= 1'b0;
      r_sel   <= 1'b0;
    end else begin
      if (i_fire) r_sel <= w_arm_eff && w_bit;
      if (i_post_clr)  r_armed <= 1'b0;
      else if (i_fire) r_armed <= w_arm_eff;
    end
  end

  assign o_sel = r_sel;

endmodule

// File: rtl/mdc_switch_ctrl.sv
// Sequencing controller for the MDC FFT commutators: frame counter, per-stage sel, drain.
// Optional frame_cnt output is enabled by defining MDC_SWITCH_CTRL_FRAME_CNT_EN.
import fft_ctrl_pkg::*;

module mdc_switch_ctrl #(
  parameter int unsigned MAX_LOG2N = DEF_MAX_LOG2N,
  parameter int unsigned MIN_LOG2N = DEF_MIN_LOG2N
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           cfg_log2n,
  input  logic                 in_start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic                 adv,
  output logic [MAX_LOG2N-2:0] sel,
  output logic                 busy,
  output logic                 done,
`ifdef MDC_SWITCH_CTRL_FRAME_CNT_EN
  output logic                 cfg_err,
  output logic [15:0]          frame_cnt
`else
  output logic                 cfg_err
`endif
);

  localparam int unsigned GW    = MAX_LOG2N;
  localparam int unsigned NS    = MAX_LOG2N - 1;
  localparam logic [3:0]  MIN_L = 4'(MIN_LOG2N);
  localparam logic [3:0]  MAX_L = 4'(MAX_LOG2N);

  state_t        r_state, w_nxt_state;
  logic [GW-1:0] r_g, r_dcnt, w_nxt_dcnt;
  logic [GW-1:0] w_idx, w_mask, w_nxt_g, w_drain_last;
  logic [3:0]    r_l, w_l;
  logic          r_adv, r_done, r_cfg_err, r_flush_pend;
  logic          w_fire, w_pre_clr, w_post_clr, w_done, w_cfg_err, w_nxt_pend;
  logic          w_cfg_ok, w_wrap, w_new_frame;

  assign w_cfg_ok     = (cfg_log2n >= MIN_L) && (cfg_log2n <= MAX_L);
  assign w_new_frame  = in_valid && in_start && w_cfg_ok &&
                        ((r_state == IDLE) || ((r_state == RUN) && (r_g == '0)));
  assign w_l          = w_new_frame ? cfg_log2n : r_l;
  assign w_idx        = ((r_state != DRAIN) && in_start) ? '0 : r_g;
  assign w_mask       = GW'((32'd1 << w_l) - 32'd1);
  assign w_wrap       = (w_idx == w_mask);
  assign w_nxt_g      = (w_idx + GW'(1)) & w_mask;
  assign w_drain_last = GW'(drain_len(32'(r_l)) - 32'd1);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_dcnt  = r_dcnt;
    w_nxt_pend  = r_flush_pend;
    w_fire      = 1'b0;
    w_pre_clr   = 1'b0;
    w_post_clr  = 1'b0;
    w_done      = 1'b0;
    w_cfg_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid && in_start) begin
          if (w_cfg_ok) begin
            w_fire      = 1'b1;
            w_pre_clr   = 1'b1;
            w_nxt_pend  = 1'b0;
            w_nxt_state = RUN;
          end else begin
            w_cfg_err = 1'b1;
          end
        end
      end
      RUN: begin
        if (in_valid) begin
          w_fire = 1'b1;
          if (in_start) begin
            // Resync clears arming; a frame boundary clears it only when L changes.
            if (r_g != '0)                w_pre_clr = 1'b1;
            else if (!w_cfg_ok)           w_cfg_err = 1'b1;
            else if (cfg_log2n != r_l)    w_pre_clr = 1'b1;
          end
          if ((flush || r_flush_pend) && w_wrap) begin
            w_nxt_state = DRAIN;
            w_nxt_pend  = 1'b0;
            w_nxt_dcnt  = '0;
          end else if (flush) begin
            w_nxt_pend = 1'b1;
          end
        end else if (flush) begin
          w_nxt_state = DRAIN;
          w_nxt_pend  = 1'b0;
          w_nxt_dcnt  = '0;
        end
      end
      DRAIN: begin
        w_fire     = 1'b1;
        w_nxt_dcnt = r_dcnt + GW'(1);
        if (r_dcnt == w_drain_last) begin
          w_nxt_state = IDLE;
          w_post_clr  = 1'b1;
          w_done      = 1'b1;
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_g          <= '0;
      r_l          <= MIN_L;
      r_dcnt       <= '0;
      r_flush_pend <= 1'b0;
      r_adv        <= 1'b0;
      r_done       <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_l          <= w_l;
      r_dcnt       <= w_nxt_dcnt;
      r_flush_pend <= w_nxt_pend;
      r_adv        <= w_fire;
      r_done       <= w_done;
      r_cfg_err    <= w_cfg_err;
      if (w_fire) r_g <= w_nxt_g;
    end
  end

  for (genvar s = 0; s < NS; s++) begin : g_stage
    mdc_stage_sel #(
      .MAX_LOG2N(MAX_LOG2N),
      .STAGE    (s)
    ) u_sel (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_fire    (w_fire),
      .i_pre_clr (w_pre_clr),
      .i_post_clr(w_post_clr),
      .i_idx     (w_idx),
      .i_log2n   (w_l),
      .o_sel     (sel[s])
    );
  end

`ifdef MDC_SWITCH_CTRL_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (w_fire && in_start && (r_state != DRAIN)) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

  assign adv      = r_adv;
  assign done     = r_done;
  assign cfg_err  = r_cfg_err;
  assign busy     = (r_state != IDLE);
  assign in_ready = (r_state != DRAIN);

endmodule

// File: doc/mdc_switch_ctrl.md
Name: mdc_switch_ctrl

Overview:
- Sequencing controller for the complex 2x2 switch (commutator) instances in the multimode radix-2 MDC FFT pipeline.
- Produces one registered `sel` per stage from a single frame sample counter, with per-stage arming that accounts for delay-line fill.
- Latches the FFT size (log2 N) per frame.
- Generates a flush/drain sequence that empties the delay lines after the last frame.

Parameters:
- MAX_LOG2N, 10, largest supported log2 FFT size; the number of switch stages is MAX_LOG2N-1.
- MIN_LOG2N, 3, smallest supported log2 FFT size.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- cfg_log2n  in  4  requested log2 N; sampled only at frame start.
- in_start  in  1  marks the first sample of a frame; qualified by in_valid.
- in_valid  in  1  an input sample is present this cycle.
- in_ready  out  1  controller accepts samples (low during DRAIN).
- flush  in  1  request to drain the pipeline after the current frame.
- adv  out  1  datapath advance strobe (delay lines shift).
- sel  out  MAX_LOG2N-1  per-stage switch select; bit s drives stage s.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when a drain completes.
- cfg_err  out  1  one-cycle pulse on an invalid cfg_log2n at start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; g=0; armed=0; L=MIN_LOG2N; sel=0; adv=0; done=0; cfg_err=0; busy=0; in_ready=1.
- Let L be the latched log2 N, N=2^L, and A_s = 2^(L-1) - 2^(L-1-s) (the arming offset of stage s).
- g is the frame sample counter, L bits wide, mod N.
- State machine:
  - IDLE:
    - in_valid & in_start with MIN_LOG2N <= cfg_log2n <= MAX_LOG2N: latch L; treat the sample as g=0; go to RUN.
    - Out-of-range cfg_log2n: pulse cfg_err, stay IDLE, sample dropped.
    - in_valid without in_start: ignored.
  - RUN, on each in_valid:
    - g <= g+1 mod N.
    - Stage s becomes armed (sticky) on the first sample with global index >= A_s.
    - in_start arriving when g != 0 (resync): treat the sample as g=0, keep L, clear armed; no error flag.
    - in_start at g=0 (back-to-back frame): re-sample cfg_log2n. A change of L clears armed; same L keeps the stages armed and continuous.
  - RUN -> DRAIN: flush high with no in_valid that cycle, or flush high together with the last sample of a frame (g=N-1). flush at any other point is held pending until g wraps to 0.
  - DRAIN:
    - in_ready=0; in_valid ignored.
    - adv asserted every cycle for exactly 2^(L-1)-1 cycles (total delay-line depth).
    - Counter and sel keep advancing as if valid.
    - Then pulse done and go to IDLE with armed cleared.
- adv = (accepted in_valid in RUN or IDLE-start) | DRAIN cycle, registered; one cycle after the triggering sample.
- sel[s] is registered and applies to the sample accepted in the previous cycle:
  - When stage s is armed: sel[s] = bit (L-2-s) of ((idx - A_s) mod N), where idx is that sample's g.
  - Stages s >= L-1 and unarmed stages: sel[s] = 0.
- No valid cycle: sel and adv hold (adv = 0).
- Widths: g and the subtraction are MAX_LOG2N bits, masked to L bits.
- busy = (state != IDLE), combinational from the state register.

Optional Feature:
- Macro: MDC_SWITCH_CTRL_FRAME_CNT_EN.
- When defined: adds output frame_cnt [15:0]. It increments (wrapping) on each accepted frame start, including back-to-back starts and resyncs, and resets to 0.
- When undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package fft_ctrl_pkg holds:
  - State enum IDLE/RUN/DRAIN.
  - MAX_LOG2N and MIN_LOG2N defaults.
  - Function arm_offset(L, s) returning A_s.
  - Function drain_len(L) returning 2^(L-1)-1.
- One natural sub-module: mdc_stage_sel. It is instantiated per stage and computes armed plus its sel bit from g, L and s.

Test Plan:
- cfg_log2n=3, start then 8 valid samples: next-cycle sel[0] = 0,0,1,1,0,0,1,1; sel[1] = 0,0,0,1,0,1,0,1; sel[8:2]=0; adv high 8 cycles.
- After the N=8 frame, flush with no valid: in_ready=0 and adv high for 3 cycles, then done pulse; busy falls with the state returning to IDLE.
- in_start at g=5 during an N=16 frame: g restarts at 0, armed is cleared, and sel[1] stays 0 until index 4.
- Back-to-back frames, 8 then cfg_log2n=4 at the g=0 start: L changes to 4; sel[0] follows bit 2 with period 8; stages re-arm at A = 0, 4, 6.
- Start with cfg_log2n=2, then 11: a cfg_err pulse each time, state stays IDLE, sel=0, adv=0.
- rst_n pulled low mid-DRAIN, asynchronously: all outputs return to reset values within that same cycle.
